led_pattern_sequencer: RTL and testbench
========================================

LED_PATTERN_SEQUENCER -- requirements
Module: led_pattern_sequencer

Interface
REQ-001 SHALL have parameter TICK_PERIOD, default 50_000_000: clk cycles per pattern step; legal range >= 2.
REQ-002 SHALL have parameter DB_CYCLES, default 1_000_000: consecutive stable cycles required to accept a button level change; legal range >= 2.
REQ-003 SHALL have port clk  input  1: single clock; all state on its rising edge.
REQ-004 SHALL have port rst_n  input  1: reset, asynchronous, active-low.
REQ-005 SHALL have port btn_mode  input  1: raw active-high pushbutton, asynchronous to clk; a press advances the mode.
REQ-006 SHALL have port btn_pause  input  1: raw active-high pushbutton, asynchronous to clk; a press toggles pause.
REQ-007 SHALL have port led  output  16: current LED pattern, registered.
REQ-008 SHALL have port mode  output  2: current mode; 0=BLINK, 1=SHIFT, 2=BOUNCE, 3=FILL.
REQ-009 SHALL have port paused  output  1: 1 while pattern stepping is frozen.

Function
REQ-010 Each button SHALL pass through a 2-flop synchronizer, then a debouncer.
REQ-011 Debounce rule: the debounced level SHALL change only after the synchronized level has differed from it for DB_CYCLES consecutive cycles; any mismatch gap SHALL restart the count.
REQ-012 Press event: a debounced 0->1 transition SHALL produce exactly one 1-cycle press pulse; releases SHALL produce none.
REQ-013 Tick counter: SHALL count 0..TICK_PERIOD-1 and wrap to 0; the tick pulse SHALL be high in the cycle where count == TICK_PERIOD-1.
REQ-014 While paused=1, the tick counter SHALL hold and no tick SHALL occur.
REQ-015 Mode press: mode SHALL advance 0->1->2->3->0 on the edge where the pulse is high.
REQ-016 On that same edge, led SHALL load the new mode's initial pattern, the tick counter SHALL clear to 0, and dir SHALL set to left.
REQ-017 Mode press and tick in the same cycle: the mode press SHALL win and the tick SHALL be discarded.
REQ-018 Mode presses SHALL be honoured while paused; the mode change SHALL NOT alter the paused flag.
REQ-019 Pause press: paused SHALL toggle; led SHALL hold its value while paused.
REQ-020 Simultaneous mode and pause presses SHALL both take effect on the same edge.
REQ-021 BLINK: initial 0x0000; on each tick, led <= ~led.
REQ-022 SHIFT: initial 0x0001; on each tick, rotate left by 1; 0x8000 SHALL step to 0x0001.
REQ-023 BOUNCE: initial 0x0001 with dir=left; on each tick, shift one position in dir.
REQ-024 BOUNCE end stops: at 0x8000 with dir=left, the next tick SHALL give 0x4000 and set dir=right; at 0x0001 with dir=right, the next tick SHALL give 0x0002 and set dir=left.
REQ-025 FILL: initial 0x0000; on each tick, if led==0xFFFF then led <= 0x0000, else led <= {led[14:0],1}.
REQ-026 Exactly one LED SHALL be lit at all times in SHIFT and BOUNCE modes.

Reset
REQ-027 rst_n low SHALL, without waiting for a clk edge, force: led=0x0000, mode=0, paused=0, tick counter=0, debounce counters=0, synchronizer and debounced levels=0, dir=left.
REQ-028 Reset asserted mid-pattern or mid-debounce SHALL discard all in-progress state; a button held through reset release SHALL still need DB_CYCLES of stability before a press is recognized.
REQ-029 After rst_n rises, the first tick SHALL occur TICK_PERIOD cycles later.

Verification (TICK_PERIOD=4, DB_CYCLES=3)
REQ-030 Reset then run: led=0x0000, mode=0; after 4 cycles led=0xFFFF; after 8 cycles led=0x0000.
REQ-031 btn_mode high for 2 cycles then low -> mode stays 0; btn_mode held high for 10 cycles -> mode=1 and led=0x0001, exactly one advance.
REQ-032 SHIFT for 16 ticks -> led returns to 0x0001, one bit set every step; the step after 0x8000 gives 0x0001.
REQ-033 BOUNCE -> led follows ...0x4000, 0x8000, 0x4000... and ...0x0002, 0x0001, 0x0002...; a mode press on a tick cycle -> FILL with led=0x0000 and no step applied.
REQ-034 FILL for 16 ticks -> 0x0001, 0x0003, ..., 0xFFFF; tick 17 -> 0x0000.
REQ-035 Pause press -> led and mode constant for 40 cycles; then rst_n pulsed low between edges -> led=0x0000 and paused=0 before the next clk edge.

Source files
------------

// File: rtl/led_pattern_sequencer.sv
// led_pattern_sequencer
//   Steps a 16-LED pattern once per TICK_PERIOD clocks in one of four modes
//   (BLINK, SHIFT, BOUNCE, FILL). Two raw pushbuttons are synchronized and
//   debounced: a press on btn_mode advances the mode, a press on btn_pause
//   freezes/unfreezes stepping.
//
// Ports
//   clk       in   single clock, all state on its rising edge
//   rst_n     in   asynchronous active-low reset
//   btn_mode  in   raw active-high pushbutton, advances the mode
//   btn_pause in   raw active-high pushbutton, toggles pause
//   led       out  [15:0] registered LED pattern
//   mode      out  [1:0]  0=BLINK 1=SHIFT 2=BOUNCE 3=FILL
//   paused    out  1 while stepping is frozen
module led_pattern_sequencer #(
  parameter int TICK_PERIOD = 50_000_000,
  parameter int DB_CYCLES   = 1_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        btn_mode,
  input  logic        btn_pause,
  output logic [15:0] led,
  output logic [1:0]  mode,
  output logic        paused
);

  localparam int TW = (TICK_PERIOD > 2) ? $clog2(TICK_PERIOD) : 1;
  localparam int DW = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_PERIOD - 1);
  localparam logic [DW-1:0] DB_LAST   = DW'(DB_CYCLES - 1);

  // Button lane indices inside the synchronizer/debouncer vectors.
  localparam int B_MODE  = 0;
  localparam int B_PAUSE = 1;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  typedef enum logic [1:0] {
    M_BLINK  = 2'd0,
    M_SHIFT  = 2'd1,
    M_BOUNCE = 2'd2,
    M_FILL   = 2'd3
  } mode_e;

  // Pattern loaded when a mode is entered.
  function automatic logic [15:0] init_pattern(input mode_e m);
    logic [15:0] p;
    case (m)
      M_SHIFT, M_BOUNCE: p = 16'h0001;
      default:           p = 16'h0000;
    endcase
    return p;
  endfunction

  logic [1:0]          sync1_q, sync1_d;
  logic [1:0]          sync2_q, sync2_d;
  logic [1:0]          db_lvl_q, db_lvl_d;
  logic [1:0][DW-1:0]  db_cnt_q, db_cnt_d;
  logic [1:0]          press;

  logic [TW-1:0]       tick_cnt_q, tick_cnt_d;
  logic                tick;
  mode_e               mode_q, mode_d;
  logic [15:0]         led_q, led_d;
  logic                dir_q, dir_d;
  logic                paused_q, paused_d;

  // Synchronizer and debouncer, one lane per button. The press pulse is
  // asserted in the cycle whose closing edge flips the debounced level
  // from 0 to 1, so the consequent action lands on that same edge.
  always_comb begin
    sync1_d  = {btn_pause, btn_mode};
    sync2_d  = sync1_q;
    db_lvl_d = db_lvl_q;
    db_cnt_d = db_cnt_q;
    press    = '0;
    for (int i = 0; i < 2; i++) begin
      if (sync2_q[i] != db_lvl_q[i]) begin
        if (db_cnt_q[i] == DB_LAST) begin
          db_lvl_d[i] = sync2_q[i];
          db_cnt_d[i] = '0;
          press[i]    = sync2_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + 1'b1;
        end
      end else begin
        // Any agreement restarts the stability count.
        db_cnt_d[i] = '0;
      end
    end
  end

  // Tick generation, mode/pause control and pattern stepping.
  always_comb begin
    tick       = !paused_q && (tick_cnt_q == TICK_LAST);
    mode_d     = mode_q;
    led_d      = led_q;
    dir_d      = dir_q;
    tick_cnt_d = tick_cnt_q;
    paused_d   = paused_q ^ press[B_PAUSE];

    if (press[B_MODE]) begin
      // A mode press overrides any tick in the same cycle.
      mode_d     = mode_e'(mode_q + 2'd1);
      led_d      = init_pattern(mode_d);
      dir_d      = DIR_LEFT;
      tick_cnt_d = '0;
    end else if (!paused_q) begin
      if (tick) begin
        tick_cnt_d = '0;
        case (mode_q)
          M_BLINK: led_d = ~led_q;
          M_SHIFT: led_d = {led_q[14:0], led_q[15]};
          M_BOUNCE: begin
            if (dir_q == DIR_LEFT) begin
              if (led_q[15]) begin
                led_d = 16'h4000;
                dir_d = DIR_RIGHT;
              end else begin
                led_d = led_q << 1;
              end
            end else begin
              if (led_q[0]) begin
                led_d = 16'h0002;
                dir_d = DIR_LEFT;
              end else begin
                led_d = led_q >> 1;
              end
            end
          end
          M_FILL:  led_d = (led_q == 16'hFFFF) ? 16'h0000 : {led_q[14:0], 1'b1};
          default: led_d = led_q;
        endcase
      end else begin
        tick_cnt_d = tick_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      db_lvl_q   <= '0;
      db_cnt_q   <= '0;
      tick_cnt_q <= '0;
      mode_q     <= M_BLINK;
      led_q      <= 16'h0000;
      dir_q      <= DIR_LEFT;
      paused_q   <= 1'b0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      db_lvl_q   <= db_lvl_d;
      db_cnt_q   <= db_cnt_d;
      tick_cnt_q <= tick_cnt_d;
      mode_q     <= mode_d;
      led_q      <= led_d;
      dir_q      <= dir_d;
      paused_q   <= paused_d;
    end
  end

  assign led    = led_q;
  assign mode   = mode_q;
  assign paused = paused_q;

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// tb_led_pattern_sequencer
//   Directed bench for led_pattern_sequencer with TICK_PERIOD=4, DB_CYCLES=3.
//   A button asserted just after an edge yields its press on the 5th edge
//   (2 synchronizer flops + 3 stable cycles).
module tb_led_pattern_sequencer;

  logic        clk;
  logic        rst_n;
  logic        btn_mode;
  logic        btn_pause;
  logic [15:0] led;
  logic [1:0]  mode;
  logic        paused;

  int n_total = 0;
  int n_bad   = 0;

  led_pattern_sequencer #(
    .TICK_PERIOD (4),
    .DB_CYCLES   (3)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn_mode  (btn_mode),
    .btn_pause (btn_pause),
    .led       (led),
    .mode      (mode),
    .paused    (paused)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Advance n rising edges and sample 1 time unit later.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Assert the chosen buttons, advance to the edge where the press lands,
  // then release.
  task automatic press(input logic do_mode, input logic do_pause);
    btn_mode  = do_mode;
    btn_pause = do_pause;
    step(5);
    btn_mode  = 1'b0;
    btn_pause = 1'b0;
  endtask

  initial begin
    logic [15:0] e;
    logic [16:0] f;
    int          pos;
    int          dir;

    rst_n     = 1'b0;
    btn_mode  = 1'b0;
    btn_pause = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_led", led, 32'h0000);
    chk("rst_mode", mode, 0);
    chk("rst_paused", paused, 0);
    @(negedge clk) rst_n = 1'b1;

    // BLINK: first tick lands 4 edges after release.
    step(3);
    chk("blink_pre_tick", led, 32'h0000);
    step(1);
    chk("blink_tick1", led, 32'hFFFF);
    step(3);
    chk("blink_hold", led, 32'hFFFF);
    step(1);
    chk("blink_tick2", led, 32'h0000);

    // Two-cycle glitch is rejected.
    btn_mode = 1'b1;
    step(2);
    btn_mode = 1'b0;
    step(6);
    chk("glitch_mode", mode, 0);

    // Held press: exactly one advance.
    btn_mode = 1'b1;
    step(4);
    chk("press_early_mode", mode, 0);
    step(1);
    chk("press_mode", mode, 1);
    chk("press_led", led, 32'h0001);

    // SHIFT across 16 ticks, including the wrap.
    for (int k = 1; k <= 16; k++) begin
      step(4);
      if (k == 1) btn_mode = 1'b0;
      e = 16'h0001 << (k % 16);
      chk($sformatf("shift_k%0d", k), led, e);
      chk("shift_onehot", $countones(led), 1);
    end
    chk("shift_mode_kept", mode, 1);

    // BOUNCE.
    press(1'b1, 1'b0);
    chk("bounce_mode", mode, 2);
    chk("bounce_init", led, 32'h0001);
    pos = 0;
    dir = 0;
    for (int k = 1; k <= 31; k++) begin
      if (dir == 0) begin
        if (pos == 15) begin pos = 14; dir = 1; end
        else pos = pos + 1;
      end else begin
        if (pos == 0) begin pos = 1; dir = 0; end
        else pos = pos - 1;
      end
      step(4);
      e = 16'h0001 << pos;
      chk($sformatf("bounce_k%0d", k), led, e);
      chk("bounce_onehot", $countones(led), 1);
    end

    // Mode press arriving on a tick cycle: FILL initial value, no step.
    step(3);
    press(1'b1, 1'b0);
    chk("fill_mode", mode, 3);
    chk("fill_init", led, 32'h0000);

    for (int k = 1; k <= 17; k++) begin
      step(4);
      f = (17'd1 << k) - 17'd1;
      e = (k == 17) ? 16'h0000 : f[15:0];
      chk($sformatf("fill_k%0d", k), led, e);
    end

    // Pause: tick 18 (0x0001) lands one edge before the pause takes hold.
    press(1'b0, 1'b1);
    chk("pause_flag", paused, 1);
    chk("pause_led", led, 32'h0001);
    chk("pause_mode", mode, 3);

    // Mode presses honoured while paused; pause flag untouched.
    press(1'b1, 1'b0);
    chk("pmode_mode", mode, 0);
    chk("pmode_led", led, 32'h0000);
    chk("pmode_paused", paused, 1);
    step(4);
    chk("pmode_frozen", led, 32'h0000);
    step(1);
    press(1'b1, 1'b0);
    chk("pmode2_mode", mode, 1);
    chk("pmode2_led", led, 32'h0001);
    chk("pmode2_paused", paused, 1);

    for (int i = 0; i < 5; i++) begin
      step(8);
      chk("hold_led", led, 32'h0001);
      chk("hold_mode", mode, 1);
    end

    // Asynchronous reset between edges, with btn_mode held through it.
    #2;
    rst_n    = 1'b0;
    btn_mode = 1'b1;
    #1;
    chk("arst_led", led, 32'h0000);
    chk("arst_mode", mode, 0);
    chk("arst_paused", paused, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    step(4);
    chk("rel_mode_early", mode, 0);
    step(1);
    chk("rel_mode", mode, 1);
    chk("rel_led", led, 32'h0001);

    // Simultaneous mode and pause presses.
    btn_mode = 1'b0;
    step(5);
    press(1'b1, 1'b1);
    chk("both_mode", mode, 2);
    chk("both_paused", paused, 1);
    chk("both_led", led, 32'h0001);
    step(4);
    chk("both_frozen", led, 32'h0001);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
